// File: rtl/prog_clock_divider.sv
// Multi-channel runtime-programmable clock divider / tick generator.
// Optional CLKDIV_SYNC_EN adds a sync_all input that restarts every channel in phase.
module prog_clock_divider_ch #(
  parameter int WIDTH        = 32,
  parameter int DEFAULT_HALF = 250000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             wr,
  input  logic [WIDTH-1:0] wr_half,
  input  logic             sync,
  output logic             clk_out,
  output logic             tick,
  output logic             pending
);
  logic [WIDTH-1:0] half, pend_half, cnt;
  logic             run, tc, apply;

  always_comb begin
    run   = en && (half != '0);
    tc    = run && (cnt == half - WIDTH'(1));
    // New divisor only lands at the end of a full period, or at once when stopped
    apply = pending && ((half == '0) || (tc && clk_out));
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      half      <= WIDTH'(DEFAULT_HALF);
      pend_half <= '0;
      pending   <= 1'b0;
      cnt       <= '0;
      clk_out   <= 1'b0;
      tick      <= 1'b0;
    end else begin
      if (wr) begin
        pending   <= 1'b1;
        pend_half <= wr_half;
      end else if (apply) begin
        pending   <= 1'b0;
      end
      if (apply) half <= pend_half;

      if (sync || half == '0) begin
        cnt     <= '0;
        clk_out <= 1'b0;
        tick    <= 1'b0;
      end else if (tc) begin
        cnt     <= '0;
        clk_out <= ~clk_out;
        tick    <= ~clk_out;
      end else if (run) begin
        cnt     <= cnt + WIDTH'(1);
        tick    <= 1'b0;
      end else begin
        tick    <= 1'b0;
      end
    end
  end
endmodule

module prog_clock_divider #(
  parameter int N_CH         = 4,
  parameter int WIDTH        = 32,
  parameter int DEFAULT_HALF = 250000,
  parameter int CH_W         = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_CH-1:0]  en,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [CH_W-1:0]  cfg_ch,
  input  logic [WIDTH-1:0] cfg_half,
`ifdef CLKDIV_SYNC_EN
  input  logic             sync_all,
`endif
  output logic [N_CH-1:0]  clk_out,
  output logic [N_CH-1:0]  tick
);
  logic [N_CH-1:0] pending, wr;
  logic            sync;

`ifdef CLKDIV_SYNC_EN
  assign sync = sync_all;
`else
  assign sync = 1'b0;
`endif

  // Out-of-range channel never matches, so it is accepted and dropped
  always_comb begin
    cfg_ready = 1'b1;
    for (int i = 0; i < N_CH; i++)
      if (cfg_ch == CH_W'(i) && pending[i]) cfg_ready = 1'b0;
  end

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    assign wr[i] = cfg_valid && cfg_ready && (cfg_ch == CH_W'(i));
    prog_clock_divider_ch #(.WIDTH(WIDTH), .DEFAULT_HALF(DEFAULT_HALF)) u_ch (
      .clk     (clk),
      .rst     (rst),
      .en      (en[i]),
      .wr      (wr[i]),
      .wr_half (cfg_half),
      .sync    (sync),
      .clk_out (clk_out[i]),
      .tick    (tick[i]),
      .pending (pending[i])
    );
  end
endmodule

// File: tb/tb_prog_clock_divider.sv
// Directed bench for prog_clock_divider: table of reset-run vectors plus corner-case sequences.
module tb_prog_clock_divider;
  localparam int N_CH = 4, WIDTH = 8, CH_W = 2;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic [N_CH-1:0]  en = '1;
  logic             cfg_valid = 1'b0;
  logic             cfg_ready;
  logic [CH_W-1:0]  cfg_ch = '0;
  logic [WIDTH-1:0] cfg_half = '0;
  logic             sync_all = 1'b0;
  logic [N_CH-1:0]  clk_out, tick;

  int total = 0, bad = 0;

  prog_clock_divider #(.N_CH(N_CH), .WIDTH(WIDTH), .DEFAULT_HALF(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .cfg_valid (cfg_valid),
    .cfg_ready (cfg_ready),
    .cfg_ch    (cfg_ch),
    .cfg_half  (cfg_half),
`ifdef CLKDIV_SYNC_EN
    .sync_all  (sync_all),
`endif
    .clk_out   (clk_out),
    .tick      (tick)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] en;
    logic [3:0] clk;
    logic [3:0] tick;
  } vec_t;
  vec_t tbl[16];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    cfg_valid = 1'b0;
    en = '1;
    sync_all = 1'b0;
    rst = 1'b0;
    #1;
    chk("rst_clk_out", 32'(clk_out), 0);
    chk("rst_tick", 32'(tick), 0);
    step();
    step();
    chk("rst_clk_out_hold", 32'(clk_out), 0);
    rst = 1'b1;
  endtask

  initial begin
    // 1: default half=4 on all channels, edges 1..16 after release
    tbl[0]  = '{4'hF, 4'h0, 4'h0};
    tbl[1]  = '{4'hF, 4'h0, 4'h0};
    tbl[2]  = '{4'hF, 4'h0, 4'h0};
    tbl[3]  = '{4'hF, 4'hF, 4'hF};
    tbl[4]  = '{4'hF, 4'hF, 4'h0};
    tbl[5]  = '{4'hF, 4'hF, 4'h0};
    tbl[6]  = '{4'hF, 4'hF, 4'h0};
    tbl[7]  = '{4'hF, 4'h0, 4'h0};
    tbl[8]  = '{4'hF, 4'h0, 4'h0};
    tbl[9]  = '{4'hF, 4'h0, 4'h0};
    tbl[10] = '{4'hF, 4'h0, 4'h0};
    tbl[11] = '{4'hF, 4'hF, 4'hF};
    tbl[12] = '{4'hF, 4'hF, 4'h0};
    tbl[13] = '{4'hF, 4'hF, 4'h0};
    tbl[14] = '{4'hF, 4'hF, 4'h0};
    tbl[15] = '{4'hF, 4'h0, 4'h0};

    #2;
    do_reset();
    chk("rst_ready", 32'(cfg_ready), 1);
    for (int i = 0; i < 16; i++) begin
      en = tbl[i].en;
      step();
      chk($sformatf("tbl_clk[%0d]", i), 32'(clk_out), 32'(tbl[i].clk));
      chk($sformatf("tbl_tick[%0d]", i), 32'(tick), 32'(tbl[i].tick));
    end

    // 2: ch1 half 4 -> 2 written in high phase, applied at the 1->0 edge
    do_reset();
    for (int i = 0; i < 5; i++) step();
    cfg_valid = 1'b1; cfg_ch = 2'd1; cfg_half = 8'd2;
    chk("t2_ready_pre", 32'(cfg_ready), 1);
    step();                               // edge 6 accepts
    cfg_valid = 1'b0;
    chk("t2_ready_e6", 32'(cfg_ready), 0);
    chk("t2_clk_e6", 32'(clk_out[1]), 1);
    step();
    chk("t2_ready_e7", 32'(cfg_ready), 0);
    chk("t2_clk_e7", 32'(clk_out[1]), 1);
    step();
    chk("t2_ready_e8", 32'(cfg_ready), 1);
    chk("t2_clk_e8", 32'(clk_out[1]), 0);
    begin
      logic [7:0] e_clk, e_tick;
      e_clk  = 8'b0110_0110;
      e_tick = 8'b0010_0010;
      for (int k = 0; k < 8; k++) begin
        step();
        chk($sformatf("t2_clk1[%0d]", k + 9), 32'(clk_out[1]), 32'(e_clk[k]));
        chk($sformatf("t2_tick1[%0d]", k + 9), 32'(tick[1]), 32'(e_tick[k]));
      end
    end
    chk("t2_ch0_e16", 32'(clk_out[0]), 0);

    // 3: stop ch2 with half=0, then restart with half=3
    do_reset();
    step();
    cfg_valid = 1'b1; cfg_ch = 2'd2; cfg_half = 8'd0;
    step();                               // edge 2 accepts
    cfg_valid = 1'b0;
    for (int n = 3; n <= 15; n++) begin
      step();
      chk($sformatf("t3_clk2[%0d]", n), 32'(clk_out[2]), 32'(n >= 4 && n <= 7));
      chk($sformatf("t3_tick2[%0d]", n), 32'(tick[2]), 32'(n == 4));
    end
    cfg_valid = 1'b1; cfg_half = 8'd3;
    chk("t3_ready", 32'(cfg_ready), 1);
    step();                               // edge 16 accepts
    cfg_valid = 1'b0;
    step(); chk("t3_e17", 32'(clk_out[2]), 0);
    step(); chk("t3_e18", 32'(clk_out[2]), 0);
    step(); chk("t3_e19", 32'(clk_out[2]), 0);
    step();
    chk("t3_e20_clk", 32'(clk_out[2]), 1);
    chk("t3_e20_tick", 32'(tick[2]), 1);
    step();
    chk("t3_e21_clk", 32'(clk_out[2]), 1);
    chk("t3_e21_tick", 32'(tick[2]), 0);
    step(); step();
    chk("t3_e23_clk", 32'(clk_out[2]), 0);

    // 4: en[0] low for 5 edges mid-count delays ch0 by exactly 5
    do_reset();
    step(); step();
    en = 4'b1110;
    for (int n = 3; n <= 7; n++) begin
      step();
      chk($sformatf("t4_frz_clk[%0d]", n), 32'(clk_out), (n >= 4) ? 32'hE : 32'h0);
      chk($sformatf("t4_frz_tick0[%0d]", n), 32'(tick[0]), 0);
    end
    en = 4'hF;
    step(); chk("t4_e8", 32'(clk_out[0]), 0);
    step();
    chk("t4_e9_clk", 32'(clk_out[0]), 1);
    chk("t4_e9_tick", 32'(tick[0]), 1);

    // 5: reset mid-period with a pending write
    do_reset();
    for (int i = 0; i < 5; i++) step();
    cfg_valid = 1'b1; cfg_ch = 2'd0; cfg_half = 8'd2;
    step();                               // edge 6 accepts
    cfg_valid = 1'b0;
    chk("t5_pre_clk", 32'(clk_out), 32'hF);
    chk("t5_pre_ready", 32'(cfg_ready), 0);
    do_reset();
    chk("t5_ready", 32'(cfg_ready), 1);
    step(); step(); step();
    chk("t5_e3", 32'(clk_out), 0);
    step();
    chk("t5_e4", 32'(clk_out), 32'hF);
    for (int i = 0; i < 4; i++) step();
    chk("t5_e8", 32'(clk_out), 0);

`ifdef CLKDIV_SYNC_EN
    // 6: ch0/ch1 half=3 out of phase, realigned by sync_all
    do_reset();
    step();
    cfg_valid = 1'b1; cfg_ch = 2'd0; cfg_half = 8'd3;
    step();
    cfg_ch = 2'd1;
    step();
    cfg_valid = 1'b0;
    for (int i = 0; i < 5; i++) step();   // edge 8 applies both
    en = 4'b1101;
    step();
    en = 4'hF;
    step(); step();
    chk("t6_skew", 32'(clk_out[1:0]), 32'h1);
    step();
    sync_all = 1'b1;
    step();
    sync_all = 1'b0;
    chk("t6_sync", 32'(clk_out[1:0]), 0);
    begin
      logic [5:0] e6;
      e6 = 6'b000111;
      for (int k = 0; k < 6; k++) begin
        step();
        chk($sformatf("t6_al0[%0d]", k), 32'(clk_out[0]), 32'(e6[(k + 4) % 6]));
        chk($sformatf("t6_al1[%0d]", k), 32'(clk_out[1]), 32'(e6[(k + 4) % 6]));
      end
    end
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
